fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the jump-address logic.
- Owns the program counter and drives the instruction-memory request.
- Captures fetched instructions into the IF/ID register; ID-stage jump logic takes PC-region bits from IF_PCPlus4[31:28].
- Accepts redirects from that jump logic (JumpAddress) and from EX-stage branch resolution. Handles stalls, flushes and redirects that arrive while a memory access is still outstanding.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Stall  in  1  hazard unit: hold PC and IF/ID contents.
- Jump  in  1  ID stage: take JumpAddress.
- JumpAddress  in  32  jump target (j/jal/jr).
- Branch  in  1  EX stage: branch taken.
- BranchTarget  in  32  branch target.
- IMemReady  in  1  instruction memory: IMemInstr valid this cycle, access complete.
- IMemInstr  in  32  instruction memory read data.
- IMemReq  out  1  fetch request.
- IMemAddr  out  32  fetch address.
- PCResult  out  32  current PC register.
- IF_Instruction  out  32  IF/ID instruction.
- IF_PCPlus4  out  32  IF/ID PC+4.
- IF_Valid  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset (asynchronous, any state, any cycle):
  - PC=RESET_PC; pending target=0; state=FETCH.
  - IF_Instruction=0; IF_PCPlus4=0; IF_Valid=0.
  - IMemReq=0 while Reset is high; any outstanding access is abandoned.
- Outputs:
  - IMemReq=1 in every state when Reset is low.
  - IMemAddr=PC in all states.
  - PCResult=PC.
- Handshake: while IMemReq=1 and IMemReady=0, IMemAddr must not change. PC is never updated during an outstanding access; pending redirects are held in a separate register.
- Redirect target: Branch wins over Jump (the branch instruction is older). Target bits [1:0] are forced to 2'b00.
- PC+4 is modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000.
- States:
  - FETCH: access issued to PC this cycle.
  - WAIT: access outstanding, no redirect pending.
  - DISCARD: access outstanding, redirect pending, data will be dropped.
- FETCH/WAIT, IMemReady=1, redirect (Branch|Jump): PC<=target; IF_Valid<=0, IF_Instruction<=0 (flush); state->FETCH. Redirect overrides Stall.
- FETCH/WAIT, IMemReady=1, no redirect, Stall=0: IF_Instruction<=IMemInstr; IF_PCPlus4<=PC+4; IF_Valid<=1; PC<=PC+4; state->FETCH.
- FETCH/WAIT, IMemReady=1, no redirect, Stall=1: PC and IF/ID hold; data dropped. Next cycle re-fetches the same PC (memory reads are side-effect free).
- FETCH/WAIT, IMemReady=0, no redirect: state->WAIT; PC holds. IF_Valid<=0 if Stall=0; IF/ID holds if Stall=1.
- FETCH/WAIT, IMemReady=0, redirect: pending<=target; IF_Valid<=0, IF_Instruction<=0; state->DISCARD.
- DISCARD, IMemReady=0:
  - Further redirect overwrites pending (Branch priority applies).
  - IF_Valid stays 0 regardless of Stall.
- DISCARD, IMemReady=1:
  - Data dropped; PC<=pending, or the new target if a redirect is present this cycle; state->FETCH; IF_Valid stays 0.
- Latency:
  - Zero-wait memory: one instruction per cycle; an instruction at PC appears in IF/ID the edge after IMemReady.
  - Redirect: exactly one bubble when memory is ready.

Test Plan:
- Reset mid-WAIT with RESET_PC=32'h0040_0000 -> PC=32'h0040_0000, IF_Valid=0, IMemReq=0 immediately (no clock edge). After release, IMemAddr=32'h0040_0000.
- IMemReady=1 constant, instructions A,B,C -> IF_Instruction A,B,C on consecutive edges; IF_PCPlus4=4,8,12; PC=12 after three edges.
- Jump=1, JumpAddress=32'h0000_1003 at PC=8, ready -> next PC=32'h0000_1000, IF_Valid=0 for one cycle. Same cycle with Branch=1, BranchTarget=32'h200 -> PC=32'h200.
- IMemReady low for 3 cycles at PC=16, Stall=0 -> IMemAddr stays 16, state WAIT, IF_Valid=0; on ready, IF captures word, PC=20.
- Branch=1, BranchTarget=32'h80 while waiting at PC=16 -> IMemAddr stays 16 until ready; that data is dropped; next IMemAddr=32'h80, no instruction from 16 ever has IF_Valid=1.
- PC=32'hFFFF_FFFC, ready -> IF_PCPlus4=0, PC=0. Stall=1 with ready at PC=0 -> PC and IF/ID unchanged, same address re-issued.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit
// -----------------------------------------------------------------------------
// Instruction-fetch stage. Owns the program counter, issues instruction-memory
// requests, and fills the IF/ID pipeline register. Redirects come from the
// ID-stage jump logic (Jump/JumpAddress) and from EX-stage branch resolution
// (Branch/BranchTarget). Redirects that arrive while a memory access is still
// outstanding are parked in a pending register, so the request address stays
// stable until the memory completes.
//
// Parameters:
//   RESET_PC        PC value loaded on reset
//
// Ports:
//   Clk             system clock, rising edge
//   Reset           asynchronous, active-high reset
//   Stall           hold PC and IF/ID contents
//   Jump            ID stage: take JumpAddress
//   JumpAddress     jump target
//   Branch          EX stage: branch taken (wins over Jump)
//   BranchTarget    branch target
//   IMemReady       memory: IMemInstr valid, access complete
//   IMemInstr       memory read data
//   IMemReq         fetch request (high whenever Reset is low)
//   IMemAddr        fetch address (always the PC register)
//   PCResult        current PC register
//   IF_Instruction  IF/ID instruction
//   IF_PCPlus4      IF/ID PC+4
//   IF_Valid        IF/ID holds a real instruction
// -----------------------------------------------------------------------------
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Jump,
  input  logic [31:0] JumpAddress,
  input  logic        Branch,
  input  logic [31:0] BranchTarget,
  input  logic        IMemReady,
  input  logic [31:0] IMemInstr,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  output logic [31:0] PCResult,
  output logic [31:0] IF_Instruction,
  output logic [31:0] IF_PCPlus4,
  output logic        IF_Valid
);

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,  // access issued to PC this cycle
    ST_WAIT    = 2'd1,  // access outstanding, no redirect pending
    ST_DISCARD = 2'd2   // access outstanding, its data will be dropped
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] pending_reg, pending_next;
  logic [31:0] if_instr_reg, if_instr_next;
  logic [31:0] if_pcplus4_reg, if_pcplus4_next;
  logic        if_valid_reg, if_valid_next;

  logic        redirect;
  logic [31:0] redirect_raw;
  logic [31:0] redirect_target;
  logic [31:0] pc_plus4;

  // The branch is the older instruction, so it takes priority over a jump.
  assign redirect        = Branch | Jump;
  assign redirect_raw    = Branch ? BranchTarget : JumpAddress;
  assign redirect_target = redirect_raw & ~32'h0000_0003;

  // Wraps naturally at 2^32.
  assign pc_plus4 = pc_reg + 32'd4;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg      <= ST_FETCH;
      pc_reg         <= RESET_PC;
      pending_reg    <= 32'h0000_0000;
      if_instr_reg   <= 32'h0000_0000;
      if_pcplus4_reg <= 32'h0000_0000;
      if_valid_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      pending_reg    <= pending_next;
      if_instr_reg   <= if_instr_next;
      if_pcplus4_reg <= if_pcplus4_next;
      if_valid_reg   <= if_valid_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    pending_next    = pending_reg;
    if_instr_next   = if_instr_reg;
    if_pcplus4_next = if_pcplus4_reg;
    if_valid_next   = if_valid_reg;

    unique case (state_reg)
      ST_FETCH, ST_WAIT: begin
        if (IMemReady) begin
          state_next = ST_FETCH;
          if (redirect) begin
            // Redirect overrides Stall: the instruction just fetched is on
            // the wrong path, so flush IF/ID and go to the target.
            pc_next       = redirect_target;
            if_instr_next = 32'h0000_0000;
            if_valid_next = 1'b0;
          end else if (!Stall) begin
            if_instr_next   = IMemInstr;
            if_pcplus4_next = pc_plus4;
            if_valid_next   = 1'b1;
            pc_next         = pc_plus4;
          end
          // Stall with no redirect: data dropped, same PC re-issued next
          // cycle (reads are side-effect free).
        end else begin
          if (redirect) begin
            // PC must stay put until this access finishes; park the target.
            state_next    = ST_DISCARD;
            pending_next  = redirect_target;
            if_instr_next = 32'h0000_0000;
            if_valid_next = 1'b0;
          end else begin
            state_next = ST_WAIT;
            if (!Stall) begin
              if_valid_next = 1'b0;
            end
          end
        end
      end

      ST_DISCARD: begin
        if (IMemReady) begin
          // Data from the abandoned path is dropped; a redirect arriving
          // this very cycle is newer than the parked one.
          state_next = ST_FETCH;
          pc_next    = redirect ? redirect_target : pending_reg;
        end else if (redirect) begin
          pending_next = redirect_target;
        end
        if_valid_next = 1'b0;
      end

      default: begin
        state_next = ST_FETCH;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign IMemReq        = ~Reset;
  assign IMemAddr       = pc_reg;
  assign PCResult       = pc_reg;
  assign IF_Instruction = if_instr_reg;
  assign IF_PCPlus4     = if_pcplus4_reg;
  assign IF_Valid       = if_valid_reg;

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Stall;
  logic        Jump;
  logic [31:0] JumpAddress;
  logic        Branch;
  logic [31:0] BranchTarget;
  logic        IMemReady;
  logic [31:0] IMemInstr;

  logic        IMemReq,   h_IMemReq;
  logic [31:0] IMemAddr,  h_IMemAddr;
  logic [31:0] PCResult,  h_PCResult;
  logic [31:0] IF_Instruction, h_IF_Instruction;
  logic [31:0] IF_PCPlus4,     h_IF_PCPlus4;
  logic        IF_Valid,       h_IF_Valid;

  always #5 Clk = ~Clk;

  fetch_pc_unit #(.RESET_PC(32'h0000_0000)) dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Jump(Jump),
    .JumpAddress(JumpAddress), .Branch(Branch), .BranchTarget(BranchTarget),
    .IMemReady(IMemReady), .IMemInstr(IMemInstr),
    .IMemReq(IMemReq), .IMemAddr(IMemAddr), .PCResult(PCResult),
    .IF_Instruction(IF_Instruction), .IF_PCPlus4(IF_PCPlus4), .IF_Valid(IF_Valid)
  );

  // Second instance with a non-zero reset vector, used for the reset test.
  fetch_pc_unit #(.RESET_PC(32'h0040_0000)) dut_hi (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Jump(Jump),
    .JumpAddress(JumpAddress), .Branch(Branch), .BranchTarget(BranchTarget),
    .IMemReady(IMemReady), .IMemInstr(IMemInstr),
    .IMemReq(h_IMemReq), .IMemAddr(h_IMemAddr), .PCResult(h_PCResult),
    .IF_Instruction(h_IF_Instruction), .IF_PCPlus4(h_IF_PCPlus4), .IF_Valid(h_IF_Valid)
  );

  typedef struct {
    logic        stall, jump, branch, ready;
    logic [31:0] jaddr, btgt, instr;
    logic [31:0] exp_addr, exp_pc, exp_ins, exp_p4;
    logic        exp_valid;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] pc, ins, p4;
    logic        valid;
  } exp_t;

  vec_t vecs[30];
  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(input logic st, input logic jp, input logic [31:0] ja,
                              input logic br, input logic [31:0] bt, input logic rdy,
                              input logic [31:0] ins, input logic [31:0] ea,
                              input logic [31:0] epc, input logic [31:0] eins,
                              input logic [31:0] ep4, input logic ev);
    vec_t v;
    v.stall = st; v.jump = jp; v.jaddr = ja; v.branch = br; v.btgt = bt;
    v.ready = rdy; v.instr = ins; v.exp_addr = ea; v.exp_pc = epc;
    v.exp_ins = eins; v.exp_p4 = ep4; v.exp_valid = ev;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  task automatic drive(input vec_t v);
    Stall = v.stall; Jump = v.jump; JumpAddress = v.jaddr;
    Branch = v.branch; BranchTarget = v.btgt;
    IMemReady = v.ready; IMemInstr = v.instr;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    //           st  jp  jaddr         br  btgt          rdy instr         addr          pc            ins           p4            v
    vecs[0]  = mk(0, 0, 32'h0,        0, 32'h0,        1, 32'h1111_1111, 32'h0000_0000, 32'h0000_0004, 32'h1111_1111, 32'h0000_0004, 1);
    vecs[1]  = mk(0, 0, 32'h0,        0, 32'h0,        1, 32'h2222_2222, 32'h0000_0004, 32'h0000_0008, 32'h2222_2222, 32'h0000_0008, 1);
    vecs[2]  = mk(0, 0, 32'h0,        0, 32'h0,        1, 32'h3333_3333, 32'h0000_0008, 32'h0000_000C, 32'h3333_3333, 32'h0000_000C, 1);
    vecs[3]  = mk(0, 1, 32'h0000_1003, 0, 32'h0,       1, 32'hABAB_ABAB, 32'h0000_000C, 32'h0000_1000, 32'h0,         32'h0000_000C, 0);
    vecs[4]  = mk(0, 0, 32'h0,        0, 32'h0,        1, 32'h4444_4444, 32'h0000_1000, 32'h0000_1004, 32'h4444_4444, 32'h0000_1004, 1);
    vecs[5]  = mk(0, 1, 32'h0000_1003, 1, 32'h0000_0200, 1, 32'hABAB_ABAB, 32'h0000_1004, 32'h0000_0200, 32'h0,      32'h0000_1004, 0);
    vecs[6]  = mk(0, 0, 32'h0,        1, 32'h0000_0011, 1, 32'hABAB_ABAB, 32'h0000_0200, 32'h0000_0010, 32'h0,       32'h0000_1004, 0);
    vecs[7]  = mk(0, 0, 32'h0,        0, 32'h0,        0, 32'hBAD0_0001, 32'h0000_0010, 32'h0000_0010, 32'h0,         32'h0000_1004, 0);
    vecs[8]  = mk(0, 0, 32'h0,        0, 32'h0,        0, 32'hBAD0_0002, 32'h0000_0010, 32'h0000_0010, 32'h0,         32'h0000_1004, 0);
    vecs[9]  = mk(0, 0, 32'h0,        0, 32'h0,        0, 32'hBAD0_0003, 32'h0000_0010, 32'h0000_0010, 32'h0,         32'h0000_1004, 0);
    vecs[10] = mk(0, 0, 32'h0,        0, 32'h0,        1, 32'h5555_5555, 32'h0000_0010, 32'h0000_0014, 32'h5555_5555, 32'h0000_0014, 1);
    vecs[11] = mk(0, 0, 32'h0,        1, 32'h0000_0010, 1, 32'hABAB_ABAB, 32'h0000_0014, 32'h0000_0010, 32'h0,       32'h0000_0014, 0);
    vecs[12] = mk(0, 0, 32'h0,        1, 32'h0000_0080, 0, 32'hBAD0_0004, 32'h0000_0010, 32'h0000_0010, 32'h0,       32'h0000_0014, 0);
    vecs[13] = mk(0, 0, 32'h0,        0, 32'h0,        0, 32'hBAD0_0005, 32'h0000_0010, 32'h0000_0010, 32'h0,         32'h0000_0014, 0);
    vecs[14] = mk(0, 0, 32'h0,        0, 32'h0,        1, 32'hDEAD_BEEF, 32'h0000_0010, 32'h0000_0080, 32'h0,         32'h0000_0014, 0);
    vecs[15] = mk(0, 0, 32'h0,        0, 32'h0,        1, 32'h6666_6666, 32'h0000_0080, 32'h0000_0084, 32'h6666_6666, 32'h0000_0084, 1);
    vecs[16] = mk(0, 1, 32'h0000_0300, 0, 32'h0,       0, 32'hBAD0_0006, 32'h0000_0084, 32'h0000_0084, 32'h0,         32'h0000_0084, 0);
    vecs[17] = mk(0, 1, 32'h0000_0500, 1, 32'h0000_0400, 0, 32'hBAD0_0007, 32'h0000_0084, 32'h0000_0084, 32'h0,      32'h0000_0084, 0);
    vecs[18] = mk(1, 0, 32'h0,        0, 32'h0,        0, 32'hBAD0_0008, 32'h0000_0084, 32'h0000_0084, 32'h0,         32'h0000_0084, 0);
    vecs[19] = mk(0, 0, 32'h0,        0, 32'h0,        1, 32'hBAD0_0009, 32'h0000_0084, 32'h0000_0400, 32'h0,         32'h0000_0084, 0);
    vecs[20] = mk(0, 0, 32'h0,        0, 32'h0,        1, 32'h7777_7777, 32'h0000_0400, 32'h0000_0404, 32'h7777_7777, 32'h0000_0404, 1);
    vecs[21] = mk(1, 0, 32'h0,        0, 32'h0,        0, 32'hBAD0_000A, 32'h0000_0404, 32'h0000_0404, 32'h7777_7777, 32'h0000_0404, 1);
    vecs[22] = mk(0, 0, 32'h0,        0, 32'h0,        0, 32'hBAD0_000B, 32'h0000_0404, 32'h0000_0404, 32'h7777_7777, 32'h0000_0404, 0);
    vecs[23] = mk(0, 1, 32'hFFFF_FFFF, 0, 32'h0,       1, 32'hABAB_ABAB, 32'h0000_0404, 32'hFFFF_FFFC, 32'h0,         32'h0000_0404, 0);
    vecs[24] = mk(0, 0, 32'h0,        0, 32'h0,        1, 32'h8888_8888, 32'hFFFF_FFFC, 32'h0000_0000, 32'h8888_8888, 32'h0000_0000, 1);
    vecs[25] = mk(1, 0, 32'h0,        0, 32'h0,        1, 32'h9999_9999, 32'h0000_0000, 32'h0000_0000, 32'h8888_8888, 32'h0000_0000, 1);
    vecs[26] = mk(1, 0, 32'h0,        0, 32'h0,        1, 32'h9999_9999, 32'h0000_0000, 32'h0000_0000, 32'h8888_8888, 32'h0000_0000, 1);
    vecs[27] = mk(0, 0, 32'h0,        0, 32'h0,        1, 32'hAAAA_AAAA, 32'h0000_0000, 32'h0000_0004, 32'hAAAA_AAAA, 32'h0000_0004, 1);
    vecs[28] = mk(0, 0, 32'h0,        1, 32'h0000_0600, 0, 32'hBAD0_000C, 32'h0000_0004, 32'h0000_0004, 32'h0,       32'h0000_0004, 0);
    vecs[29] = mk(0, 1, 32'h0000_0700, 0, 32'h0,       1, 32'hBAD0_000D, 32'h0000_0004, 32'h0000_0700, 32'h0,         32'h0000_0004, 0);

    // Reset
    Reset = 1'b1;
    drive(mk(0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 0));
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_pc",      PCResult,        32'h0);
    chk("rst_ins",     IF_Instruction,  32'h0);
    chk("rst_p4",      IF_PCPlus4,      32'h0);
    chk("rst_valid",   {31'h0, IF_Valid}, 32'h0);
    chk("rst_req",     {31'h0, IMemReq},  32'h0);
    chk("rst_hi_pc",   h_PCResult,      32'h0040_0000);
    Reset = 1'b0;

    // Table-driven main sequence with scoreboard
    for (int i = 0; i < 30; i++) begin
      drive(vecs[i]);
      e.idx = i; e.pc = vecs[i].exp_pc; e.ins = vecs[i].exp_ins;
      e.p4 = vecs[i].exp_p4; e.valid = vecs[i].exp_valid;
      sb_q.push_back(e);
      @(negedge Clk);
      chk($sformatf("v%0d_addr", i), IMemAddr, vecs[i].exp_addr);
      chk($sformatf("v%0d_req", i), {31'h0, IMemReq}, 32'h1);
      @(posedge Clk);
      #1;
      e = sb_q.pop_front();
      chk($sformatf("v%0d_pc", e.idx),    PCResult,       e.pc);
      chk($sformatf("v%0d_ins", e.idx),   IF_Instruction, e.ins);
      chk($sformatf("v%0d_p4", e.idx),    IF_PCPlus4,     e.p4);
      chk($sformatf("v%0d_valid", e.idx), {31'h0, IF_Valid}, {31'h0, e.valid});
      $display("vec %0d: addr=%h pc=%h ins=%h p4=%h valid=%0d", e.idx, vecs[e.idx].exp_addr,
               PCResult, IF_Instruction, IF_PCPlus4, IF_Valid);
    end

    // Hand-written: asynchronous reset in the middle of a wait
    drive(mk(1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 0));
    @(posedge Clk);
    @(posedge Clk);
    #2;
    Reset = 1'b1;
    #1;
    chk("amid_hi_pc",    h_PCResult,       32'h0040_0000);
    chk("amid_hi_valid", {31'h0, h_IF_Valid}, 32'h0);
    chk("amid_hi_ins",   h_IF_Instruction, 32'h0);
    chk("amid_hi_req",   {31'h0, h_IMemReq},  32'h0);
    chk("amid_req",      {31'h0, IMemReq},    32'h0);
    @(negedge Clk);
    Reset = 1'b0;
    drive(mk(0, 0, 32'h0, 0, 32'h0, 1, 32'hCAFE_F00D, 32'h0, 32'h0, 32'h0, 32'h0, 0));
    #1;
    chk("arel_hi_addr", h_IMemAddr,          32'h0040_0000);
    chk("arel_hi_req",  {31'h0, h_IMemReq},  32'h1);
    @(posedge Clk);
    #1;
    chk("arel_hi_pc",    h_PCResult,       32'h0040_0004);
    chk("arel_hi_ins",   h_IF_Instruction, 32'hCAFE_F00D);
    chk("arel_hi_p4",    h_IF_PCPlus4,     32'h0040_0004);
    chk("arel_hi_valid", {31'h0, h_IF_Valid}, 32'h1);
    $display("reset-mid-wait: hi pc=%h ins=%h valid=%0d", h_PCResult, h_IF_Instruction, h_IF_Valid);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
